rv_bpu: RTL and testbench

Parametrised branch prediction unit for the 5-stage RV64 pipeline. It replaces the small fixed-size predictor with a tagged, direct-mapped branch history table. Each entry holds a 2-bit saturating counter and a branch target. A selectable global-history (gshare) indexing mode and mispredict/branch performance counters are also provided. Lookup is combinational in IF; update arrives from EX/MEM once the branch resolves.

---
 rtl/rv_bpu.sv | 117 +++++++++++
 tb/tb_rv_bpu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_bpu.sv
// Tagged direct-mapped branch history table with 2-bit counters and stored targets.
// Optional gshare indexing, global history register and saturating perf counters.
module rv_bpu #(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 16,
  parameter int TAG_W     = 8,
  parameter int GHR_W     = 4,
  parameter int MODE      = 0,
  parameter int CNT_W     = 32,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear_i,
  input  logic             if_valid_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic [IDX_W-1:0] pred_idx_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_mispredict_i,
  output logic [CNT_W-1:0] cnt_branch_o,
  output logic [CNT_W-1:0] cnt_mispred_o
);

  // if_valid_i and upd_valid_i are single-cycle qualifiers: each asserted
  // cycle is one lookup or one update, and the unit never back-pressures.

  logic             ent_valid [BHT_DEPTH];
  logic [1:0]       ent_ctr   [BHT_DEPTH];
  logic [TAG_W-1:0] ent_tag   [BHT_DEPTH];
  logic [XLEN-1:0]  ent_tgt   [BHT_DEPTH];
  logic [GHR_W-1:0] ghr;

  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             unused_pc_bits;

  assign ghr_ext = IDX_W'(ghr);
  assign lk_idx  = (MODE == 1) ? (if_pc_i[IDX_W+1:2] ^ ghr_ext) : if_pc_i[IDX_W+1:2];
  assign lk_tag  = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit  = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);

  assign pred_taken_o  = if_valid_i && lk_hit && ent_ctr[lk_idx][1];
  assign pred_target_o = pred_taken_o ? ent_tgt[lk_idx] : (if_pc_i + XLEN'(4));
  assign pred_idx_o    = lk_idx;
  assign pred_ghr_o    = ghr;

  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_hit = ent_valid[upd_idx_i] && (ent_tag[upd_idx_i] == upd_tag);

  // Only the index/tag slices of the PCs matter; the rest is intentionally ignored.
  assign unused_pc_bits = ^{if_pc_i, upd_pc_i};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_ctr[i]   <= 2'b01;
        ent_tag[i]   <= '0;
        ent_tgt[i]   <= '0;
      end
      ghr           <= '0;
      cnt_branch_o  <= '0;
      cnt_mispred_o <= '0;
    end else if (clear_i) begin
      // Invalidate only: counters and targets keep their values.
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
      end
      ghr <= '0;
    end else begin
      // Truncating cast of {ghr, bit} keeps the low GHR_W bits, covering GHR_W = 1.
      if (upd_valid_i && upd_mispredict_i) begin
        ghr <= GHR_W'({upd_ghr_i, upd_taken_i});
      end else if (if_valid_i && lk_hit) begin
        ghr <= GHR_W'({ghr, pred_taken_o});
      end

      if (upd_valid_i) begin
        if (upd_hit) begin
          if (upd_taken_i) begin
            if (ent_ctr[upd_idx_i] != 2'b11) begin
              ent_ctr[upd_idx_i] <= ent_ctr[upd_idx_i] + 2'b01;
            end
            ent_tgt[upd_idx_i] <= upd_target_i;
          end else if (ent_ctr[upd_idx_i] != 2'b00) begin
            ent_ctr[upd_idx_i] <= ent_ctr[upd_idx_i] - 2'b01;
          end
        end else if (upd_taken_i) begin
          ent_valid[upd_idx_i] <= 1'b1;
          ent_tag[upd_idx_i]   <= upd_tag;
          ent_tgt[upd_idx_i]   <= upd_target_i;
          ent_ctr[upd_idx_i]   <= 2'b10;
        end

        if (cnt_branch_o != {CNT_W{1'b1}}) begin
          cnt_branch_o <= cnt_branch_o + CNT_W'(1);
        end
        if (upd_mispredict_i && (cnt_mispred_o != {CNT_W{1'b1}})) begin
          cnt_mispred_o <= cnt_mispred_o + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_bpu.sv
// Bench for rv_bpu: a bimodal instance (default widths) and a gshare instance with
// 3-bit perf counters, checked every cycle against a behavioural table model.
module tb_rv_bpu;

  logic        clk;
  logic        rstn;
  logic        started;
  int          n_chk;
  int          n_pass;

  logic        clear     [2];
  logic        if_valid  [2];
  logic [63:0] if_pc     [2];
  logic        upd_valid [2];
  logic [63:0] upd_pc    [2];
  logic [3:0]  upd_idx   [2];
  logic [3:0]  upd_ghr   [2];
  logic        upd_taken [2];
  logic [63:0] upd_tgt   [2];
  logic        upd_mis   [2];

  logic        pt   [2];
  logic [63:0] ptgt [2];
  logic [3:0]  pidx [2];
  logic [3:0]  pghr [2];
  logic [31:0] cb0, cm0;
  logic [2:0]  cb1, cm1;

  rv_bpu #(.MODE(0)) dut_b (
    .clk(clk), .rstn(rstn), .clear_i(clear[0]),
    .if_valid_i(if_valid[0]), .if_pc_i(if_pc[0]),
    .pred_taken_o(pt[0]), .pred_target_o(ptgt[0]), .pred_idx_o(pidx[0]), .pred_ghr_o(pghr[0]),
    .upd_valid_i(upd_valid[0]), .upd_pc_i(upd_pc[0]), .upd_idx_i(upd_idx[0]), .upd_ghr_i(upd_ghr[0]),
    .upd_taken_i(upd_taken[0]), .upd_target_i(upd_tgt[0]), .upd_mispredict_i(upd_mis[0]),
    .cnt_branch_o(cb0), .cnt_mispred_o(cm0)
  );

  rv_bpu #(.MODE(1), .CNT_W(3)) dut_g (
    .clk(clk), .rstn(rstn), .clear_i(clear[1]),
    .if_valid_i(if_valid[1]), .if_pc_i(if_pc[1]),
    .pred_taken_o(pt[1]), .pred_target_o(ptgt[1]), .pred_idx_o(pidx[1]), .pred_ghr_o(pghr[1]),
    .upd_valid_i(upd_valid[1]), .upd_pc_i(upd_pc[1]), .upd_idx_i(upd_idx[1]), .upd_ghr_i(upd_ghr[1]),
    .upd_taken_i(upd_taken[1]), .upd_target_i(upd_tgt[1]), .upd_mispredict_i(upd_mis[1]),
    .cnt_branch_o(cb1), .cnt_mispred_o(cm1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_valid [2][16];
  int          m_ctr   [2][16];
  int          m_tag   [2][16];
  logic [63:0] m_tgt   [2][16];
  int          m_ghr   [2];
  longint      m_cb    [2];
  longint      m_cm    [2];

  function automatic longint cnt_max(int k);
    return (k == 0) ? 64'hffff_ffff : 64'd7;
  endfunction

  function automatic int f_tag(logic [63:0] pc);
    return int'((pc >> 6) & 64'hff);
  endfunction

  function automatic int f_idx(int k, logic [63:0] pc);
    int base;
    base = int'((pc >> 2) & 64'hf);
    return (k == 1) ? (base ^ m_ghr[k]) : base;
  endfunction

  function automatic bit f_hit(int k, logic [63:0] pc);
    int i;
    i = f_idx(k, pc);
    return m_valid[k][i] && (m_tag[k][i] == f_tag(pc));
  endfunction

  function automatic bit f_taken(int k);
    return if_valid[k] && f_hit(k, if_pc[k]) && (m_ctr[k][f_idx(k, if_pc[k])] >= 2);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[k][i] <= 1'b0;
          m_ctr[k][i]   <= 1;
          m_tag[k][i]   <= 0;
          m_tgt[k][i]   <= 64'd0;
        end
        m_ghr[k] <= 0;
        m_cb[k]  <= 0;
        m_cm[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (clear[k]) begin
          for (int i = 0; i < 16; i++) m_valid[k][i] <= 1'b0;
          m_ghr[k] <= 0;
        end else begin
          if (upd_valid[k] && upd_mis[k])
            m_ghr[k] <= ((int'(upd_ghr[k]) * 2) + int'(upd_taken[k])) % 16;
          else if (if_valid[k] && f_hit(k, if_pc[k]))
            m_ghr[k] <= ((m_ghr[k] * 2) + int'(f_taken(k))) % 16;
          if (upd_valid[k]) begin
            if (m_valid[k][upd_idx[k]] && m_tag[k][upd_idx[k]] == f_tag(upd_pc[k])) begin
              if (upd_taken[k]) begin
                m_ctr[k][upd_idx[k]] <= (m_ctr[k][upd_idx[k]] < 3) ? m_ctr[k][upd_idx[k]] + 1 : 3;
                m_tgt[k][upd_idx[k]] <= upd_tgt[k];
              end else begin
                m_ctr[k][upd_idx[k]] <= (m_ctr[k][upd_idx[k]] > 0) ? m_ctr[k][upd_idx[k]] - 1 : 0;
              end
            end else if (upd_taken[k]) begin
              m_valid[k][upd_idx[k]] <= 1'b1;
              m_tag[k][upd_idx[k]]   <= f_tag(upd_pc[k]);
              m_tgt[k][upd_idx[k]]   <= upd_tgt[k];
              m_ctr[k][upd_idx[k]]   <= 2;
            end
            if (m_cb[k] < cnt_max(k)) m_cb[k] <= m_cb[k] + 1;
            if (upd_mis[k] && m_cm[k] < cnt_max(k)) m_cm[k] <= m_cm[k] + 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic [63:0] e_tgt;
        int          ei;
        ei    = f_idx(k, if_pc[k]);
        e_tgt = f_taken(k) ? m_tgt[k][ei] : if_pc[k] + 64'd4;
        chk($sformatf("model_taken[%0d]", k), 64'(pt[k]), 64'(f_taken(k)));
        chk($sformatf("model_target[%0d]", k), ptgt[k], e_tgt);
        chk($sformatf("model_idx[%0d]", k), 64'(pidx[k]), 64'(ei));
        chk($sformatf("model_ghr[%0d]", k), 64'(pghr[k]), 64'(m_ghr[k]));
      end
      chk("model_cnt_branch[0]", 64'(cb0), 64'(m_cb[0]));
      chk("model_cnt_mispred[0]", 64'(cm0), 64'(m_cm[0]));
      chk("model_cnt_branch[1]", 64'(cb1), 64'(m_cb[1]));
      chk("model_cnt_mispred[1]", 64'(cm1), 64'(m_cm[1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      clear[k] = 1'b0; if_valid[k] = 1'b0; if_pc[k] = 64'd0;
      upd_valid[k] = 1'b0; upd_pc[k] = 64'd0; upd_idx[k] = 4'd0; upd_ghr[k] = 4'd0;
      upd_taken[k] = 1'b0; upd_tgt[k] = 64'd0; upd_mis[k] = 1'b0;
    end
  endtask

  task automatic set_upd(int k, logic [63:0] pc, logic [3:0] idx, logic [3:0] g,
                         logic tk, logic [63:0] tgt, logic mis);
    upd_valid[k] = 1'b1; upd_pc[k] = pc; upd_idx[k] = idx; upd_ghr[k] = g;
    upd_taken[k] = tk; upd_tgt[k] = tgt; upd_mis[k] = mis;
  endtask

  task automatic upd(int k, logic [63:0] pc, logic [3:0] idx, logic [3:0] g,
                     logic tk, logic [63:0] tgt, logic mis);
    set_upd(k, pc, idx, g, tk, tgt, mis);
    @(posedge clk); #1;
    upd_valid[k] = 1'b0; clear[k] = 1'b0;
  endtask

  // Lookup with literal expectations; e_ghr < 0 skips the history check.
  task automatic lookup_chk(int k, logic [63:0] pc, logic e_tk, logic [63:0] e_tgt,
                            logic [3:0] e_idx, int e_ghr, string nm);
    if_valid[k] = 1'b1; if_pc[k] = pc;
    @(negedge clk);
    chk({nm, "_taken"}, 64'(pt[k]), 64'(e_tk));
    chk({nm, "_target"}, ptgt[k], e_tgt);
    chk({nm, "_idx"}, 64'(pidx[k]), 64'(e_idx));
    if (e_ghr >= 0) chk({nm, "_ghr"}, 64'(pghr[k]), 64'(e_ghr));
    @(posedge clk); #1;
    if_valid[k] = 1'b0;
  endtask

  task automatic cnt_chk(string nm, logic [63:0] act_sel, logic [63:0] e);
    chk(nm, act_sel, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_chk = 0; n_pass = 0; started = 1'b0;
    rstn = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1 started = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;

    // bimodal: reset state and first allocation
    lookup_chk(0, 64'h100, 1'b0, 64'h104, 4'd0, 0, "reset_lookup");
    @(negedge clk); cnt_chk("reset_cnt_branch", 64'(cb0), 64'd0);
    @(posedge clk); #1;
    upd(0, 64'h100, 4'd0, 4'd0, 1'b1, 64'h80, 1'b1);
    lookup_chk(0, 64'h100, 1'b1, 64'h80, 4'd0, -1, "alloc_lookup");
    @(negedge clk); cnt_chk("alloc_cnt_branch", 64'(cb0), 64'd1);
    @(posedge clk); #1;

    // counter saturation and hysteresis
    upd(0, 64'h100, 4'd0, 4'd0, 1'b1, 64'h80, 1'b0);
    upd(0, 64'h100, 4'd0, 4'd0, 1'b1, 64'h80, 1'b0);
    upd(0, 64'h100, 4'd0, 4'd0, 1'b0, 64'h0, 1'b1);
    lookup_chk(0, 64'h100, 1'b1, 64'h80, 4'd0, -1, "ctr10_lookup");
    upd(0, 64'h100, 4'd0, 4'd0, 1'b0, 64'h0, 1'b1);
    lookup_chk(0, 64'h100, 1'b0, 64'h104, 4'd0, -1, "ctr01_lookup");
    @(negedge clk);
    cnt_chk("hyst_cnt_branch", 64'(cb0), 64'd5);
    cnt_chk("hyst_cnt_mispred", 64'(cm0), 64'd3);
    @(posedge clk); #1;

    // aliasing: 0x140 shares index 0 with a different tag
    lookup_chk(0, 64'h140, 1'b0, 64'h144, 4'd0, -1, "alias_miss");
    upd(0, 64'h140, 4'd0, 4'd0, 1'b1, 64'h200, 1'b1);
    lookup_chk(0, 64'h140, 1'b1, 64'h200, 4'd0, -1, "alias_replace");
    lookup_chk(0, 64'h100, 1'b0, 64'h104, 4'd0, -1, "alias_old_miss");

    // clear beats a same-cycle update; perf counters hold
    clear[0] = 1'b1;
    upd(0, 64'h100, 4'd0, 4'd0, 1'b1, 64'h300, 1'b0);
    lookup_chk(0, 64'h140, 1'b0, 64'h144, 4'd0, 0, "clear_miss_a");
    lookup_chk(0, 64'h100, 1'b0, 64'h104, 4'd0, 0, "clear_miss_b");
    @(negedge clk); cnt_chk("clear_cnt_branch", 64'(cb0), 64'd6);
    @(posedge clk); #1;

    // gshare: predicted-taken lookup shifts history
    upd(1, 64'h100, 4'd0, 4'd0, 1'b1, 64'h80, 1'b0);
    lookup_chk(1, 64'h100, 1'b1, 64'h80, 4'd0, 0, "gs_hit");
    upd(1, 64'h100, 4'd1, 4'd0, 1'b1, 64'h90, 1'b0);
    // hit lookup and mispredict in the same cycle: update history wins
    if_valid[1] = 1'b1; if_pc[1] = 64'h100;
    set_upd(1, 64'h108, 4'd2, 4'b0010, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    chk("gs_same_taken", 64'(pt[1]), 64'd1);
    chk("gs_same_target", ptgt[1], 64'h90);
    chk("gs_same_idx", 64'(pidx[1]), 64'd1);
    chk("gs_same_ghr", 64'(pghr[1]), 64'd1);
    @(posedge clk); #1;
    if_valid[1] = 1'b0; upd_valid[1] = 1'b0;
    lookup_chk(1, 64'h100, 1'b0, 64'h104, 4'd4, 4, "gs_after_mis");
    @(negedge clk);
    cnt_chk("gs_cnt_mispred", 64'(cm1), 64'd1);
    cnt_chk("gs_cnt_branch", 64'(cb1), 64'd3);
    @(posedge clk); #1;

    // 3-bit perf counters saturate at 7
    for (int n = 0; n < 6; n++) upd(1, 64'h108, 4'd2, 4'd0, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    cnt_chk("sat_cnt_branch_a", 64'(cb1), 64'd7);
    cnt_chk("sat_cnt_mispred_a", 64'(cm1), 64'd7);
    @(posedge clk); #1;
    upd(1, 64'h108, 4'd2, 4'd0, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    cnt_chk("sat_cnt_branch_b", 64'(cb1), 64'd7);
    cnt_chk("sat_cnt_mispred_b", 64'(cm1), 64'd7);
    @(posedge clk); #1;

    // a few more mixed updates under the per-cycle model
    for (int n = 0; n < 8; n++) begin
      if_valid[0] = 1'b1; if_pc[0] = 64'h140 + 64'(n * 4);
      upd(0, 64'h140 + 64'(n * 4), 4'(n), 4'(n), n[0], 64'h1000 + 64'(n * 16), n[1]);
    end
    if_valid[0] = 1'b0;

    // mid-operation reset drops the in-flight update
    if_valid[0] = 1'b1; if_pc[0] = 64'h140;
    set_upd(0, 64'h140, 4'd0, 4'd0, 1'b1, 64'h500, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_taken", 64'(pt[0]), 64'd0);
    chk("midrst_target", ptgt[0], 64'h144);
    chk("midrst_cnt_branch", 64'(cb0), 64'd0);
    @(posedge clk); #1;
    upd_valid[0] = 1'b0; if_valid[0] = 1'b0; rstn = 1'b1;
    lookup_chk(0, 64'h140, 1'b0, 64'h144, 4'd0, 0, "post_rst");

    @(posedge clk); #1;
    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
